// File: rtl/bist_controller_if.sv
// Pin-side and CUT-side signal bundle of the BIST controller.
// master: chip/pin side (drives mode, pins and CUT responses).
// slave : the controller itself.
interface bist_controller_if #(
  parameter int PI_W = 35,
  parameter int PO_W = 49
);
  logic            bistmode;
  logic [PI_W-1:0] pi;
  logic [PO_W-1:0] cut_po;
  logic [PI_W-1:0] cut_pi;
  logic            cut_rst;
  logic            bistdone;
  logic            bistpass;

  modport master (
    output bistmode, pi, cut_po,
    input  cut_pi, cut_rst, bistdone, bistpass
  );

  modport slave (
    input  bistmode, pi, cut_po,
    output cut_pi, cut_rst, bistdone, bistpass
  );
endinterface

// File: rtl/bist_controller.sv
// BIST controller: functional passthrough of pins to the CUT, or an LFSR
// pattern run with MISR compaction and a golden-signature verdict.
// Optional macro BIST_CUT_RESET_EN: also holds the CUT in reset during INIT
// so the signature does not depend on prior functional activity.
//
// state   | meaning
// IDLE    | functional mode, cut_pi follows pi
// INIT    | reload LFSR seed, clear MISR and pattern count
// RUN     | apply one LFSR pattern and compact CUT outputs per cycle
// COMPARE | final signature vs golden, verdict registered
// DONE    | verdict held until reset
module bist_controller #(
  parameter int              PI_W       = 35,
  parameter int              PO_W       = 49,
  parameter int              PAT_COUNT  = 2000,
  parameter logic [PI_W-1:0] LFSR_SEED  = 35'h1,
  parameter logic [PO_W-1:0] GOLDEN_SIG = 49'h0
) (
  input  logic               clk,
  input  logic               rst,
  bist_controller_if.slave   bus
);

  localparam int CNT_W = $clog2(PAT_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAT_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [PI_W-1:0]  lfsr_q;
  logic [PI_W-1:0]  lfsr_d;
  logic [PO_W-1:0]  misr_q;
  logic [PO_W-1:0]  misr_d;
  logic [CNT_W-1:0] count_q;
  logic             done_q;
  logic             pass_q;

  // Next LFSR pattern (x^35+x^33+1) and next MISR signature (x^49+x^40+1).
  always_comb begin
    lfsr_d = {lfsr_q[PI_W-2:0], lfsr_q[PI_W-1] ^ lfsr_q[PI_W-3]};
    misr_d = {misr_q[PO_W-2:0], misr_q[PO_W-1] ^ misr_q[PO_W-10]} ^ bus.cut_po;
  end

  // Sequencer: state, pattern generator, signature register and verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.bistmode) state_q <= S_INIT;
        end
        S_INIT: begin
          if (!bus.bistmode) begin
            state_q <= S_IDLE;
          end else begin
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            count_q <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (!bus.bistmode) begin
            state_q <= S_IDLE;
          end else begin
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            count_q <= count_q + CNT_W'(1);
            if (count_q == LAST_CNT) state_q <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          // A mode drop here abandons the run without a verdict.
          if (!bus.bistmode) begin
            state_q <= S_IDLE;
          end else begin
            pass_q  <= (misr_q == GOLDEN_SIG);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cut_pi   = (state_q == S_IDLE) ? bus.pi : lfsr_q;
  assign bus.bistdone = done_q;
  assign bus.bistpass = pass_q;

`ifdef BIST_CUT_RESET_EN
  assign bus.cut_rst = rst | (state_q == S_INIT);
`else
  assign bus.cut_rst = rst;
`endif

endmodule
